// File: rtl/match_referee_pkg.sv
// Shared encodings for the fight referee: action codes, positions, FSM states and winner codes.
package match_referee_pkg;

  typedef enum logic [2:0] {
    ActKick   = 3'b000,
    ActPunch  = 3'b001,
    ActAwait  = 3'b010,
    ActJump   = 3'b011,
    ActLeft1  = 3'b100,
    ActLeft2  = 3'b101,
    ActRight1 = 3'b110,
    ActRight2 = 3'b111
  } action_e;

  typedef enum logic [1:0] {
    PosFarLeft  = 2'b00,
    PosLeft     = 2'b01,
    PosRight    = 2'b10,
    PosFarRight = 2'b11
  } position_e;

  typedef enum logic [2:0] {
    StIdle,
    StRoundInit,
    StCollect,
    StStep,
    StCheck,
    StRoundEnd,
    StMatchEnd
  } ref_state_e;

  typedef enum logic [1:0] {
    WinNone = 2'b00,
    WinP1   = 2'b01,
    WinP2   = 2'b10,
    WinDraw = 2'b11
  } winner_e;

  // Larger value wins for player 1 / player 2; equal values are a draw.
  function automatic winner_e compare_pair(input logic [1:0] a, input logic [1:0] b);
    if (a > b) return WinP1;
    if (b > a) return WinP2;
    return WinDraw;
  endfunction

endpackage

// File: rtl/match_referee_if.sv
// Player-facing and status signals of the referee; slave is the referee side.
interface match_referee_if;
  logic       start;
  logic       valid1;
  logic       valid2;
  logic [2:0] action1_in;
  logic [2:0] action2_in;
  logic [1:0] health1;
  logic [1:0] health2;
  logic [2:0] action1;
  logic [2:0] action2;
  logic       step;
  logic       round_rst;
  logic [2:0] round_num;
  logic [5:0] turn_cnt;
  logic [1:0] score1;
  logic [1:0] score2;
  logic [1:0] winner;
  logic       done;

  modport master (
    output start, valid1, valid2, action1_in, action2_in, health1, health2,
    input  action1, action2, step, round_rst, round_num, turn_cnt, score1, score2, winner, done
  );

  modport slave (
    input  start, valid1, valid2, action1_in, action2_in, health1, health2,
    output action1, action2, step, round_rst, round_num, turn_cnt, score1, score2, winner, done
  );
endinterface

// File: rtl/match_referee_action_latch.sv
// Holds one player's first action of a turn; reads as await while empty.
module match_referee_action_latch
  import match_referee_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       valid,
  input  logic [2:0] action_in,
  output logic       full_next,
  output logic [2:0] action
);

  logic       full_q;
  logic [2:0] act_q;
  logic       capture;

  assign capture = ~clear & valid & ~full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      act_q  <= ActAwait;
    end else if (clear) begin
      full_q <= 1'b0;
      act_q  <= ActAwait;
    end else if (capture) begin
      full_q <= 1'b1;
      act_q  <= action_in;
    end
  end

  // Forward a same-cycle capture so the turn can close without an extra cycle.
  assign full_next = full_q | capture;
  assign action    = capture ? action_in : act_q;

endmodule

// File: rtl/match_referee.sv
// Fight referee: collects per-turn actions, steps both players, scores rounds and the match.
module match_referee
  import match_referee_pkg::*;
#(
  parameter int unsigned TURN_TIMEOUT = 15,
  parameter int unsigned MAX_TURNS    = 32,
  parameter int unsigned WINS_NEEDED  = 2,
  parameter int unsigned MAX_ROUNDS   = 5
) (
  input logic             clk,
  input logic             rst_n,
  match_referee_if.slave  bus
);

  localparam int unsigned TmoW = (TURN_TIMEOUT > 2) ? $clog2(TURN_TIMEOUT) : 1;

  ref_state_e      state_q, state_d;
  logic [TmoW-1:0] tmo_q;
  winner_e         result_q, check_res, winner_q;
  logic [2:0]      action1_q, action2_q, round_num_q;
  logic [5:0]      turn_cnt_q;
  logic [1:0]      score1_q, score2_q, s1_nxt, s2_nxt;
  logic            step_q, round_rst_q, done_q;
  logic            full1, full2, clear, tmo_done, match_over;
  logic [2:0]      act1, act2;

  assign clear = (state_q != StCollect);

  match_referee_action_latch u_latch1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .valid     (bus.valid1),
    .action_in (bus.action1_in),
    .full_next (full1),
    .action    (act1)
  );

  match_referee_action_latch u_latch2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .valid     (bus.valid2),
    .action_in (bus.action2_in),
    .full_next (full2),
    .action    (act2)
  );

  assign tmo_done = (tmo_q == TmoW'(TURN_TIMEOUT - 1));

  always_comb begin
    check_res = WinNone;
    if (bus.health1 == 2'd0 && bus.health2 == 2'd0) check_res = WinDraw;
    else if (bus.health1 == 2'd0)                   check_res = WinP2;
    else if (bus.health2 == 2'd0)                   check_res = WinP1;
    else if (turn_cnt_q == 6'(MAX_TURNS))           check_res = compare_pair(bus.health1,
                                                                             bus.health2);
  end

  // Scores saturate at 3.
  assign s1_nxt = (result_q == WinP1 && score1_q != 2'd3) ? score1_q + 2'd1 : score1_q;
  assign s2_nxt = (result_q == WinP2 && score2_q != 2'd3) ? score2_q + 2'd1 : score2_q;
  assign match_over = (s1_nxt == 2'(WINS_NEEDED)) || (s2_nxt == 2'(WINS_NEEDED)) ||
                      (round_num_q == 3'(MAX_ROUNDS));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      if (bus.start) state_d = StRoundInit;
      StRoundInit: state_d = StCollect;
      StCollect:   if ((full1 && full2) || tmo_done) state_d = StStep;
      StStep:      state_d = StCheck;
      StCheck:     state_d = (check_res == WinNone) ? StCollect : StRoundEnd;
      StRoundEnd:  state_d = match_over ? StMatchEnd : StRoundInit;
      StMatchEnd:  if (bus.start) state_d = StRoundInit;
      default:     state_d = StIdle;
    endcase
  end

  // Outputs are registered against the state being entered so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tmo_q       <= '0;
      result_q    <= WinNone;
      action1_q   <= ActAwait;
      action2_q   <= ActAwait;
      step_q      <= 1'b0;
      round_rst_q <= 1'b0;
      round_num_q <= 3'd0;
      turn_cnt_q  <= 6'd0;
      score1_q    <= 2'd0;
      score2_q    <= 2'd0;
      winner_q    <= WinNone;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= (state_d == StStep);
      round_rst_q <= (state_d == StRoundInit);
      tmo_q       <= (state_q == StCollect && state_d == StCollect) ? tmo_q + 1'b1 : '0;

      if (state_d == StStep) begin
        action1_q  <= act1;
        action2_q  <= act2;
        turn_cnt_q <= turn_cnt_q + 6'd1;
      end else if (state_d != StCheck) begin
        action1_q <= ActAwait;
        action2_q <= ActAwait;
      end

      if (state_d == StRoundInit) begin
        turn_cnt_q  <= 6'd0;
        round_num_q <= (state_q == StMatchEnd) ? 3'd1 : round_num_q + 3'd1;
      end

      if (state_q == StMatchEnd && state_d == StRoundInit) begin
        score1_q <= 2'd0;
        score2_q <= 2'd0;
        winner_q <= WinNone;
        done_q   <= 1'b0;
      end

      if (state_q == StCheck) result_q <= check_res;

      if (state_q == StRoundEnd) begin
        score1_q <= s1_nxt;
        score2_q <= s2_nxt;
        if (match_over) begin
          done_q   <= 1'b1;
          winner_q <= compare_pair(s1_nxt, s2_nxt);
        end
      end
    end
  end

  assign bus.action1   = action1_q;
  assign bus.action2   = action2_q;
  assign bus.step      = step_q;
  assign bus.round_rst = round_rst_q;
  assign bus.round_num = round_num_q;
  assign bus.turn_cnt  = turn_cnt_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.winner    = winner_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_match_referee.sv
// Bench for match_referee: directed turn table, randomized matches against a turn-level model.
module tb_match_referee;

  localparam int         NEVER = 31;
  localparam logic [2:0] AWAIT = 3'b010;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  match_referee_if bus ();

  match_referee dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Turn-level model of the match.
  int m_s1, m_s2, m_round, m_turn;
  bit m_done;

  typedef struct {
    int         off1;
    logic [2:0] a1;
    int         off2;
    logic [2:0] a2;
    logic [1:0] h1;
    logic [1:0] h2;
    bit         dup;
    int         exp_cyc;
    logic [2:0] exp_a1;
    logic [2:0] exp_a2;
    int         exp_s1;
    int         exp_round;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int decide(input int h1, input int h2, input int turn);
    if (h1 == 0 && h2 == 0) return 3;
    if (h1 == 0) return 2;
    if (h2 == 0) return 1;
    if (turn == 32) return (h1 > h2) ? 1 : ((h2 > h1) ? 2 : 3);
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_round = 0; m_turn = 0; m_done = 0;
  endtask

  task automatic start_match();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_s1 = 0; m_s2 = 0; m_round = 1; m_turn = 0; m_done = 0;
    check("init_round_rst", bus.round_rst, 1);
    check("init_round_num", bus.round_num, 1);
    check("init_done", bus.done, 0);
    check("init_winner", bus.winner, 0);
    check("init_score1", bus.score1, 0);
    check("init_score2", bus.score2, 0);
    check("init_step", bus.step, 0);
    tick();
    check("collect_round_rst", bus.round_rst, 0);
  endtask

  // Starts in the first COLLECT cycle of a turn; ends in the next COLLECT, or in MATCH_END.
  task automatic do_turn(input int off1, input logic [2:0] a1, input int off2,
                         input logic [2:0] a2, input logic [1:0] h1, input logic [1:0] h2,
                         input bit dup, input int exp_cyc, input logic [2:0] exp_a1,
                         input logic [2:0] exp_a2);
    int cyc;
    int res;
    cyc = 0;
    while (bus.step !== 1'b1 && cyc < 40) begin
      bus.valid1     = (cyc == off1) || (dup && cyc == off1 + 1);
      bus.action1_in = (cyc == off1) ? a1 : ~a1;
      bus.valid2     = (cyc == off2);
      bus.action2_in = a2;
      tick();
      cyc++;
    end
    m_turn++;
    check("collect_cycles", cyc, exp_cyc);
    check("step_pulse", bus.step, 1);
    check("step_action1", bus.action1, exp_a1);
    check("step_action2", bus.action2, exp_a2);
    check("step_turn_cnt", bus.turn_cnt, m_turn);
    check("step_round_rst", bus.round_rst, 0);
    bus.valid1     = 1'b1;
    bus.valid2     = 1'b1;
    bus.action1_in = 3'($urandom);
    bus.action2_in = 3'($urandom);
    bus.health1    = h1;
    bus.health2    = h2;
    tick();
    check("check_step_low", bus.step, 0);
    check("check_action1_hold", bus.action1, exp_a1);
    check("check_action2_hold", bus.action2, exp_a2);
    tick();
    bus.valid1  = 1'b0;
    bus.valid2  = 1'b0;
    bus.health1 = 2'd3;
    bus.health2 = 2'd3;
    res = decide(h1, h2, m_turn);
    if (res == 0) begin
      check("next_action1_await", bus.action1, AWAIT);
      check("next_action2_await", bus.action2, AWAIT);
      check("next_step_low", bus.step, 0);
    end else begin
      check("rend_step_low", bus.step, 0);
      check("rend_round_rst_low", bus.round_rst, 0);
      if (res == 1 && m_s1 < 3) m_s1++;
      if (res == 2 && m_s2 < 3) m_s2++;
      m_done = (m_s1 == 2 || m_s2 == 2 || m_round == 5);
      tick();
      check("score1", bus.score1, m_s1);
      check("score2", bus.score2, m_s2);
      check("done", bus.done, m_done);
      if (m_done) begin
        check("winner", bus.winner, (m_s1 > m_s2) ? 1 : ((m_s2 > m_s1) ? 2 : 3));
        check("final_round_num", bus.round_num, m_round);
        check("end_round_rst", bus.round_rst, 0);
        check("end_step", bus.step, 0);
      end else begin
        m_round++;
        m_turn = 0;
        check("rinit_round_rst", bus.round_rst, 1);
        check("rinit_round_num", bus.round_num, m_round);
        check("rinit_turn_cnt", bus.turn_cnt, 0);
        tick();
      end
    end
  endtask

  task automatic rand_turn(input logic [1:0] h1, input logic [1:0] h2);
    int         o1, o2, ec;
    logic [2:0] a1, a2, e1, e2;
    o1 = $urandom_range(0, 16);
    o2 = $urandom_range(0, 16);
    a1 = 3'($urandom);
    a2 = 3'($urandom);
    ec = (o1 < 15 && o2 < 15) ? (((o1 > o2) ? o1 : o2) + 1) : 15;
    e1 = (o1 < 15) ? a1 : AWAIT;
    e2 = (o2 < 15) ? a2 : AWAIT;
    do_turn(o1, a1, o2, a2, h1, h2, 1'($urandom_range(0, 1)), ec, e1, e2);
  endtask

  function automatic logic [1:0] rand_health();
    return ($urandom_range(0, 7) == 0) ? 2'd0 : 2'($urandom_range(1, 3));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 3'b110, 0, 3'b001, 2'd3, 2'd3, 1'b0, 1, 3'b110, 3'b001, 0, 1};
    tbl[1] = '{2, 3'b000, NEVER, 3'b111, 2'd3, 2'd3, 1'b0, 15, 3'b000, 3'b010, 0, 1};
    tbl[2] = '{3, 3'b101, 5, 3'b111, 2'd3, 2'd3, 1'b1, 6, 3'b101, 3'b111, 0, 1};
    tbl[3] = '{NEVER, 3'b000, NEVER, 3'b000, 2'd3, 2'd3, 1'b0, 15, 3'b010, 3'b010, 0, 1};
    tbl[4] = '{0, 3'b011, 0, 3'b100, 2'd3, 2'd0, 1'b0, 1, 3'b011, 3'b100, 1, 2};
    tbl[5] = '{1, 3'b001, 4, 3'b000, 2'd1, 2'd0, 1'b0, 5, 3'b001, 3'b000, 2, 2};

    bus.start = 1'b0; bus.valid1 = 1'b0; bus.valid2 = 1'b0;
    bus.action1_in = 3'b000; bus.action2_in = 3'b000;
    bus.health1 = 2'd3; bus.health2 = 2'd3;
    rst_n = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_action1", bus.action1, AWAIT);
    check("rst_action2", bus.action2, AWAIT);
    check("rst_step", bus.step, 0);
    check("rst_round_rst", bus.round_rst, 0);
    check("rst_round_num", bus.round_num, 0);
    check("rst_turn_cnt", bus.turn_cnt, 0);
    check("rst_scores", {bus.score1, bus.score2}, 0);
    check("rst_winner", bus.winner, 0);
    check("rst_done", bus.done, 0);
    rst_n = 1'b1;
    tick();
    check("idle_round_num", bus.round_num, 0);

    // Directed turns through a 2-0 match.
    start_match();
    for (int i = 0; i < 6; i++) begin
      do_turn(tbl[i].off1, tbl[i].a1, tbl[i].off2, tbl[i].a2, tbl[i].h1, tbl[i].h2,
              tbl[i].dup, tbl[i].exp_cyc, tbl[i].exp_a1, tbl[i].exp_a2);
      check("tbl_score1", bus.score1, tbl[i].exp_s1);
      check("tbl_round_num", bus.round_num, tbl[i].exp_round);
    end
    check("tbl_done", bus.done, 1);
    check("tbl_winner", bus.winner, 1);
    tick();
    check("match_end_hold", bus.done, 1);

    // Five rounds decided on equal health at the turn limit.
    start_match();
    for (int t = 0; t < 170 && !m_done; t++) rand_turn(2'd2, 2'd2);
    check("draw_done", bus.done, 1);
    check("draw_winner", bus.winner, 3);
    check("draw_round_num", bus.round_num, 5);
    check("draw_scores", {bus.score1, bus.score2}, 0);

    // Randomized matches.
    for (int m = 0; m < 3; m++) begin
      start_match();
      for (int t = 0; t < 170 && !m_done; t++) rand_turn(rand_health(), rand_health());
      check("rand_match_done", bus.done, 1);
    end

    // Asynchronous reset in the middle of a STEP cycle.
    start_match();
    do_turn(0, 3'b000, 0, 3'b001, 2'd3, 2'd0, 1'b0, 1, 3'b000, 3'b001);
    check("pre_rst_score1", bus.score1, 1);
    bus.valid1 = 1'b1; bus.action1_in = 3'b100;
    bus.valid2 = 1'b1; bus.action2_in = 3'b101;
    tick();
    bus.valid1 = 1'b0; bus.valid2 = 1'b0;
    check("pre_rst_step", bus.step, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_step", bus.step, 0);
    check("arst_round_num", bus.round_num, 0);
    check("arst_score1", bus.score1, 0);
    check("arst_action1", bus.action1, AWAIT);
    check("arst_turn_cnt", bus.turn_cnt, 0);
    tick();
    rst_n = 1'b1;
    model_reset();

    // Reset after a capture in COLLECT must discard it.
    start_match();
    bus.valid1 = 1'b1; bus.action1_in = 3'b000;
    tick();
    bus.valid1 = 1'b0;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    start_match();
    do_turn(NEVER, 3'b000, NEVER, 3'b000, 2'd3, 2'd3, 1'b0, 15, AWAIT, AWAIT);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
